// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Next-PC generator and PC register for the pipelined CPU. It decodes
//   jump/branch type of the ID-stage instruction, resolves branch conditions
//   (equality and sign tests), computes the target and owns the fetch PC.
//   It also holds the PC on stalls, defers a redirect decided during a
//   stall, supports optional branch delay slot and exception/ERET vectoring.
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   synchronous reset, active-low
//   stall            in   hazard stall, hold PC
//   ID_Valid         in   ID stage holds a real instruction
//   ID_Jump          in   00 none, 01 JUMP_IMM, 10 JUMP_REG (11 = none)
//   ID_Branch        in   000 none, 001 BEQ, 010 BNE, 011 BLEZ, 100 BGTZ,
//                         101 BLTZ, 110 BGEZ (111 = none)
//   ID_PC            in   PC of the ID instruction
//   ID_Imm           in   branch offset in words
//   ID_Target        in   J-type target field
//   ID_RsData        in   forwarded GPR[rs]
//   ID_RtData        in   forwarded GPR[rt]
//   exc_req          in   exception taken this cycle
//   eret             in   return from exception
//   epc              in   return address for eret
//   PC               out  current fetch PC (registered)
//   ID_NPCOp         out  00 PLUS4, 01 BRANCH, 10 JUMP_IMM, 11 JUMP_REG
//   flush            out  squash IF/ID instruction (same cycle as PC load)
//   redirect_pending out  deferred redirect held
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
    parameter int               DELAY_SLOT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ID_Valid,
    input  logic [1:0]       ID_Jump,
    input  logic [2:0]       ID_Branch,
    input  logic [WIDTH-1:0] ID_PC,
    input  logic [15:0]      ID_Imm,
    input  logic [25:0]      ID_Target,
    input  logic [WIDTH-1:0] ID_RsData,
    input  logic [WIDTH-1:0] ID_RtData,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] PC,
    output logic [1:0]       ID_NPCOp,
    output logic             flush,
    output logic             redirect_pending
);

    localparam logic [WIDTH-1:0] PC_INC = WIDTH'(32'd4);
    // Without a delay slot the fall-through instruction must be squashed.
    localparam logic SQUASH_ON_REDIRECT = (DELAY_SLOT == 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] OP_PLUS4    = 2'b00;
    localparam logic [1:0] OP_BRANCH   = 2'b01;
    localparam logic [1:0] OP_JUMP_IMM = 2'b10;
    localparam logic [1:0] OP_JUMP_REG = 2'b11;

    logic [WIDTH-1:0] r_pc;
    logic             r_pending;
    logic [WIDTH-1:0] r_target;

    logic             w_rs_neg;
    logic             w_rs_zero;
    logic             w_cond;
    logic [1:0]       w_npc_op;
    logic [WIDTH-1:0] w_id_pc_plus4;
    logic [WIDTH-1:0] w_br_target;
    logic [WIDTH-1:0] w_j_target;
    logic [WIDTH-1:0] w_target;
    logic             w_redirect;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_pending_next;
    logic [WIDTH-1:0] w_target_next;
    logic             w_flush;

    assign w_rs_neg      = ID_RsData[WIDTH-1];
    assign w_rs_zero     = (ID_RsData == {WIDTH{1'b0}});
    assign w_id_pc_plus4 = ID_PC + PC_INC;
    assign w_br_target   = w_id_pc_plus4 + {{(WIDTH-18){ID_Imm[15]}}, ID_Imm, 2'b00};
    assign w_j_target    = {w_id_pc_plus4[WIDTH-1:28], ID_Target, 2'b00};

    // Branch condition resolution from forwarded register data.
    always_comb begin
        w_cond = 1'b0;
        case (ID_Branch)
            3'b001:  w_cond = (ID_RsData == ID_RtData);
            3'b010:  w_cond = (ID_RsData != ID_RtData);
            3'b011:  w_cond = w_rs_neg | w_rs_zero;
            3'b100:  w_cond = ~w_rs_neg & ~w_rs_zero;
            3'b101:  w_cond = w_rs_neg;
            3'b110:  w_cond = ~w_rs_neg;
            default: w_cond = 1'b0;
        endcase
    end

    // Next-PC operation select; a held redirect masks new decisions.
    always_comb begin
        w_npc_op = OP_PLUS4;
        if (ID_Valid && !r_pending) begin
            if (ID_Jump == 2'b01) begin
                w_npc_op = OP_JUMP_IMM;
            end else if (ID_Jump == 2'b10) begin
                w_npc_op = OP_JUMP_REG;
            end else if (w_cond) begin
                w_npc_op = OP_BRANCH;
            end else begin
                w_npc_op = OP_PLUS4;
            end
        end else begin
            w_npc_op = OP_PLUS4;
        end
    end

    // Target mux for the selected operation.
    always_comb begin
        w_target = r_pc + PC_INC;
        case (w_npc_op)
            OP_BRANCH:   w_target = w_br_target;
            OP_JUMP_IMM: w_target = w_j_target;
            OP_JUMP_REG: w_target = ID_RsData;
            default:     w_target = r_pc + PC_INC;
        endcase
    end

    assign w_redirect = (w_npc_op != OP_PLUS4);

    // PC update priority: exception, eret, stall, deferred redirect, redirect, +4.
    always_comb begin
        w_pc_next      = r_pc + PC_INC;
        w_pending_next = r_pending;
        w_target_next  = r_target;
        w_flush        = 1'b0;
        if (exc_req) begin
            w_pc_next      = EXC_VECTOR;
            w_pending_next = 1'b0;
            w_flush        = 1'b1;
        end else if (eret) begin
            w_pc_next      = epc;
            w_pending_next = 1'b0;
            w_flush        = 1'b1;
        end else if (stall) begin
            w_pc_next = r_pc;
            // Only the first redirect seen during a stall is remembered.
            if (w_redirect && !r_pending) begin
                w_target_next  = w_target;
                w_pending_next = 1'b1;
            end else begin
                w_target_next  = r_target;
                w_pending_next = r_pending;
            end
        end else if (r_pending) begin
            w_pc_next      = r_target;
            w_pending_next = 1'b0;
            w_flush        = SQUASH_ON_REDIRECT;
        end else if (w_redirect) begin
            w_pc_next = w_target;
            w_flush   = SQUASH_ON_REDIRECT;
        end else begin
            w_pc_next = r_pc + PC_INC;
        end
    end

    // PC, pending flag and stored target registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_pending <= 1'b0;
            r_target  <= {WIDTH{1'b0}};
        end else begin
            r_pc      <= w_pc_next;
            r_pending <= w_pending_next;
            r_target  <= w_target_next;
        end
    end

    assign PC               = r_pc;
    assign ID_NPCOp         = w_npc_op;
    assign flush            = rst & w_flush;
    assign redirect_pending = r_pending;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ID_Valid;
    logic [1:0]  ID_Jump;
    logic [2:0]  ID_Branch;
    logic [31:0] ID_PC;
    logic [15:0] ID_Imm;
    logic [25:0] ID_Target;
    logic [31:0] ID_RsData;
    logic [31:0] ID_RtData;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;

    logic [31:0] pc1, pc0;
    logic [1:0]  op1, op0;
    logic        fl1, fl0;
    logic        pend1, pend0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(32), .DELAY_SLOT(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ID_Valid(ID_Valid),
        .ID_Jump(ID_Jump), .ID_Branch(ID_Branch), .ID_PC(ID_PC),
        .ID_Imm(ID_Imm), .ID_Target(ID_Target), .ID_RsData(ID_RsData),
        .ID_RtData(ID_RtData), .exc_req(exc_req), .eret(eret), .epc(epc),
        .PC(pc1), .ID_NPCOp(op1), .flush(fl1), .redirect_pending(pend1)
    );

    pc_sequencer #(.WIDTH(32), .DELAY_SLOT(0)) dut_nds (
        .clk(clk), .rst(rst), .stall(stall), .ID_Valid(ID_Valid),
        .ID_Jump(ID_Jump), .ID_Branch(ID_Branch), .ID_PC(ID_PC),
        .ID_Imm(ID_Imm), .ID_Target(ID_Target), .ID_RsData(ID_RsData),
        .ID_RtData(ID_RtData), .exc_req(exc_req), .eret(eret), .epc(epc),
        .PC(pc0), .ID_NPCOp(op0), .flush(fl0), .redirect_pending(pend0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // combinational NPC op check for one branch code
    task automatic chk_br(input string tag, input logic [2:0] code, input logic [1:0] exp);
        ID_Branch = code;
        settle();
        chk(tag, {30'd0, op1}, {30'd0, exp});
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; ID_Valid = 1'b0; ID_Jump = 2'b00;
        ID_Branch = 3'b000; ID_PC = 32'h0; ID_Imm = 16'h0; ID_Target = 26'h0;
        ID_RsData = 32'h0; ID_RtData = 32'h0; exc_req = 1'b0; eret = 1'b0;
        epc = 32'h0;

        // reset
        tick();
        tick();
        chk("rst_pc", pc1, 32'h0000_3000);
        chk("rst_pend", {31'd0, pend1}, 32'd0);
        exc_req = 1'b1;
        settle();
        chk("rst_flush_gated", {31'd0, fl1}, 32'd0);
        chk("rst_flush_gated_nds", {31'd0, fl0}, 32'd0);
        exc_req = 1'b0;
        rst = 1'b1;
        tick();
        chk("pc_3004", pc1, 32'h0000_3004);
        tick();
        chk("pc_3008", pc1, 32'h0000_3008);

        // BEQ taken backwards
        ID_Valid = 1'b1; ID_Branch = 3'b001; ID_PC = 32'h0000_3010;
        ID_Imm = 16'hFFFC; ID_RsData = 32'd5; ID_RtData = 32'd5;
        settle();
        chk("beq_op", {30'd0, op1}, 32'd1);
        chk("beq_flush_ds1", {31'd0, fl1}, 32'd0);
        chk("beq_flush_ds0", {31'd0, fl0}, 32'd1);
        tick();
        chk("beq_pc", pc1, 32'h0000_3004);
        chk("beq_pc_nds", pc0, 32'h0000_3004);

        // BEQ not taken
        ID_RtData = 32'd6;
        settle();
        chk("beq_nt_op", {30'd0, op1}, 32'd0);
        chk("beq_nt_flush_ds0", {31'd0, fl0}, 32'd0);
        tick();
        chk("beq_nt_pc", pc1, 32'h0000_3008);

        // BNE taken forward: 0x3014 + 0x40
        ID_Branch = 3'b010; ID_Imm = 16'h0010;
        settle();
        chk("bne_op", {30'd0, op1}, 32'd1);
        tick();
        chk("bne_pc", pc1, 32'h0000_3054);

        // sign branches, combinational only
        ID_RsData = 32'hFFFF_FFFF;
        chk_br("blez_neg", 3'b011, 2'b01);
        chk_br("bgtz_neg", 3'b100, 2'b00);
        chk_br("bltz_neg", 3'b101, 2'b01);
        chk_br("bgez_neg", 3'b110, 2'b00);
        ID_RsData = 32'h0;
        chk_br("blez_zero", 3'b011, 2'b01);
        chk_br("bgtz_zero", 3'b100, 2'b00);
        chk_br("bltz_zero", 3'b101, 2'b00);
        chk_br("bgez_zero", 3'b110, 2'b01);
        ID_RsData = 32'd5;
        chk_br("bgtz_pos", 3'b100, 2'b01);
        ID_RtData = 32'd5;
        chk_br("code7_none", 3'b111, 2'b00);

        // valid gating and jump priority
        ID_Branch = 3'b001;
        ID_Valid = 1'b0;
        settle();
        chk("invalid_op", {30'd0, op1}, 32'd0);
        ID_Valid = 1'b1; ID_Jump = 2'b11;
        settle();
        chk("jump11_is_none", {30'd0, op1}, 32'd1);
        ID_Jump = 2'b10;
        settle();
        chk("jreg_over_branch", {30'd0, op1}, 32'd3);

        // JUMP_IMM: {0x0, 0x1234, 00} = 0x48D0
        ID_Jump = 2'b01; ID_Target = 26'h000_1234;
        settle();
        chk("jimm_op", {30'd0, op1}, 32'd2);
        tick();
        chk("jimm_pc", pc1, 32'h0000_48D0);
        ID_Valid = 1'b0; ID_Jump = 2'b00; ID_Branch = 3'b000;

        // deferred JUMP_REG across a 3-cycle stall
        stall = 1'b1; ID_Valid = 1'b1; ID_Jump = 2'b10; ID_RsData = 32'h0000_4000;
        settle();
        chk("stall_flush_ds0", {31'd0, fl0}, 32'd0);
        tick();
        chk("stall1_pc", pc1, 32'h0000_48D0);
        chk("stall1_pend", {31'd0, pend1}, 32'd1);
        ID_RsData = 32'h0000_5000;
        settle();
        chk("pending_masks_op", {30'd0, op1}, 32'd0);
        tick();
        chk("stall2_pc", pc1, 32'h0000_48D0);
        tick();
        chk("stall3_pc", pc1, 32'h0000_48D0);
        chk("stall3_pend", {31'd0, pend1}, 32'd1);
        stall = 1'b0;
        settle();
        chk("deferred_flush_ds1", {31'd0, fl1}, 32'd0);
        chk("deferred_flush_ds0", {31'd0, fl0}, 32'd1);
        tick();
        chk("deferred_pc", pc1, 32'h0000_4000);
        chk("deferred_pend_clr", {31'd0, pend1}, 32'd0);
        ID_Valid = 1'b0; ID_Jump = 2'b00;
        tick();
        chk("after_deferred_pc", pc1, 32'h0000_4004);

        // exception overrides a held redirect under stall
        stall = 1'b1; ID_Valid = 1'b1; ID_Jump = 2'b10; ID_RsData = 32'h0000_6000;
        tick();
        chk("exc_pre_pend", {31'd0, pend1}, 32'd1);
        exc_req = 1'b1;
        settle();
        chk("exc_flush_ds1", {31'd0, fl1}, 32'd1);
        chk("exc_flush_ds0", {31'd0, fl0}, 32'd1);
        tick();
        chk("exc_pc", pc1, 32'h0000_4180);
        chk("exc_pend_clr", {31'd0, pend1}, 32'd0);
        exc_req = 1'b0; ID_Valid = 1'b0; ID_Jump = 2'b00;
        eret = 1'b1; epc = 32'h0000_3020;
        settle();
        chk("eret_flush", {31'd0, fl1}, 32'd1);
        tick();
        chk("eret_pc", pc1, 32'h0000_3020);
        eret = 1'b0; stall = 1'b0;
        tick();
        chk("eret_next_pc", pc1, 32'h0000_3024);

        // reset while a redirect is pending
        stall = 1'b1; ID_Valid = 1'b1; ID_Jump = 2'b10; ID_RsData = 32'h0000_7000;
        tick();
        chk("rp_pend", {31'd0, pend1}, 32'd1);
        rst = 1'b0;
        tick();
        chk("rp_pc", pc1, 32'h0000_3000);
        chk("rp_pend_clr", {31'd0, pend1}, 32'd0);
        rst = 1'b1; stall = 1'b0; ID_Valid = 1'b0; ID_Jump = 2'b00;
        tick();
        chk("rp_no_stale", pc1, 32'h0000_3004);
        chk("rp_no_stale_pend", {31'd0, pend1}, 32'd0);

        // PC+4 wraps at 2^32
        ID_Valid = 1'b1; ID_Jump = 2'b10; ID_RsData = 32'hFFFF_FFFC;
        tick();
        chk("wrap_jr_pc", pc1, 32'hFFFF_FFFC);
        ID_Valid = 1'b0; ID_Jump = 2'b00;
        tick();
        chk("wrap_pc", pc1, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-PC generator and PC register for the pipelined CPU; successor to the ID-stage NPC-select logic.
- Decodes jump and branch type in ID and resolves every branch condition internally, including the new sign-test branches.
- Computes all targets and owns the PC register.
- Adds stall hold, deferred redirect across stalls, optional branch-delay-slot mode, and exception/ERET vectoring.

Parameters:
- WIDTH, 32, PC and data width (≥ 32).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception.
- DELAY_SLOT, 1, 1 = instruction after a branch/jump executes; 0 = it is squashed via flush.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- stall  in  1  hazard stall; hold PC.
- ID_Valid  in  1  ID stage holds a real instruction.
- ID_Jump  in  2  00 none, 01 JUMP_IMM, 10 JUMP_REG.
- ID_Branch  in  3  000 none, 001 BEQ, 010 BNE, 011 BLEZ, 100 BGTZ, 101 BLTZ, 110 BGEZ.
- ID_PC  in  WIDTH  PC of the ID instruction.
- ID_Imm  in  16  branch offset (words).
- ID_Target  in  26  J-type target field.
- ID_RsData  in  WIDTH  forwarded GPR[rs].
- ID_RtData  in  WIDTH  forwarded GPR[rt].
- exc_req  in  1  exception taken this cycle.
- eret  in  1  return from exception.
- epc  in  WIDTH  return address for eret.
- PC  out  WIDTH  current fetch PC.
- ID_NPCOp  out  2  00 PLUS4, 01 BRANCH, 10 JUMP_IMM, 11 JUMP_REG (combinational, this cycle's decision).
- flush  out  1  squash IF/ID instruction.
- redirect_pending  out  1  deferred redirect held.

Behaviour:
- Reset (rst=0 at edge): PC=RESET_PC, pending=0, stored target=0. flush=0 and redirect_pending=0 while in reset.
- Comparisons on ID_RsData/ID_RtData:
  - BEQ: rs==rt. BNE: rs!=rt.
  - BLEZ: rs signed ≤ 0. BGTZ: rs signed > 0. BLTZ: rs[WIDTH-1]==1. BGEZ: rs[WIDTH-1]==0.
  - ID_Branch codes 111 are treated as none.
- ID_NPCOp (only when ID_Valid=1 and pending=0, else PLUS4):
  - JUMP_IMM if ID_Jump==01.
  - Else JUMP_REG if ID_Jump==10.
  - Else BRANCH if the branch condition is true.
  - Else PLUS4.
  - ID_Jump==11 is treated as none.
- Targets (all arithmetic modulo 2^WIDTH):
  - BRANCH = ID_PC + 4 + (sign_ext(ID_Imm) << 2).
  - JUMP_IMM = {(ID_PC+4)[WIDTH-1:28], ID_Target, 2'b00}.
  - JUMP_REG = ID_RsData, taken unaligned as-is.
- Redirect = ID_NPCOp != PLUS4.
- PC update priority, per clock edge:
  1. Reset.
  2. exc_req: PC=EXC_VECTOR, pending cleared, flush=1. Applies even when stall=1.
  3. eret: PC=epc, pending cleared, flush=1. Applies even when stall=1.
  4. stall=1:
     - PC holds.
     - If redirect and pending=0: capture target, pending=1.
     - Further decisions are ignored while pending=1.
  5. stall=0 and pending=1: PC=stored target, pending=0.
  6. stall=0 and redirect: PC=target.
  7. Otherwise PC=PC+4, wrapping at 2^WIDTH.
- flush (combinational, same cycle as the PC load):
  - 1 on exc_req or eret.
  - 1 when DELAY_SLOT=0 and a redirect is applied (cases 5 or 6).
  - 0 otherwise.
  - Never asserted while stall=1 except for exc_req/eret.
- redirect_pending = pending register.
- Latency: a redirect decided in cycle n with stall=0 gives the new PC in cycle n+1.
- Reset mid-pending discards the stored target.

Test Plan:
- Reset: rst=0 for 2 cycles, then 1 → PC=32'h3000, then 32'h3004 and 32'h3008 on the following cycles.
- BEQ taken: ID_Branch=001, ID_PC=32'h3010, Imm=16'hFFFC, rs=rt=5 → ID_NPCOp=01, next PC=32'h3004. flush=0 with DELAY_SLOT=1; flush=1 with DELAY_SLOT=0.
- Sign branches: rs=32'hFFFF_FFFF → BLTZ and BLEZ taken, BGTZ and BGEZ not taken. rs=0 → BLEZ and BGEZ taken, BLTZ and BGTZ not taken.
- Deferred redirect: JUMP_REG with rs=32'h4000 while stall=1 for 3 cycles (rs changed to 32'h5000 in cycle 2) → PC held, redirect_pending=1. After stall drops, PC=32'h4000 and pending clears.
- Exception overrides: pending set and stall=1, exc_req=1 → PC=32'h4180, flush=1, pending=0. Then eret with epc=32'h3020 → PC=32'h3020.
- Reset during pending: rst=0 → PC=32'h3000, pending=0. No stale redirect occurs after rst returns to 1.
